// File: rtl/jt51_timer_pkg.sv
// rtl/jt51_timer_pkg.sv - shared defaults, mode encodings and period helper for the timer bank
package jt51_timer_pkg;

  localparam int DEF_CNT_W  = 10;
  localparam int DEF_MULT_W = 6;

  typedef enum logic {
    MODE_RELOAD  = 1'b0,
    MODE_ONESHOT = 1'b1
  } timer_mode_e;

  // Overflow period in cen ticks, counted from the tick after a load.
  function automatic longint period_ticks(input int cnt_w, input int mult_w, input longint start);
    return ((longint'(1) << cnt_w) - start) << mult_w;
  endfunction

endpackage

// File: rtl/jt51_timer_ch.sv
// rtl/jt51_timer_ch.sv - one prescaled up-counting timer channel (chain input with JT51_TIMER_BANK_CHAIN_EN)
module jt51_timer_ch
  import jt51_timer_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int MULT_W = DEF_MULT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [CNT_W-1:0] start_value,
  input  logic             load,
  input  logic             set_run,
  input  logic             clr_run,
  input  logic             clr_flag,
  input  logic             oneshot,
`ifdef JT51_TIMER_BANK_CHAIN_EN
  input  logic             chain_en,
  input  logic             chain_tick,
`endif
  output logic             flag,
  output logic             overflow,
  output logic             running
);

  localparam int ACC_W = CNT_W + MULT_W;

  logic [ACC_W-1:0] acc;
  logic             run;
  logic             adv;

  // A chained channel only steps (and can only wrap) when its predecessor overflows.
`ifdef JT51_TIMER_BANK_CHAIN_EN
  assign adv = chain_en ? chain_tick : 1'b1;
`else
  assign adv = 1'b1;
`endif

  assign overflow = run & adv & (&acc);
  assign running  = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      run  <= 1'b0;
      flag <= 1'b0;
    end else if (cen) begin
      if (load || overflow)
        acc <= {start_value, {MULT_W{1'b0}}};
      else if (run && adv)
        acc <= acc + ACC_W'(1);

      if (clr_run)
        run <= 1'b0;
      else if (set_run || load)
        run <= 1'b1;
      else if (overflow && (oneshot == MODE_ONESHOT))
        run <= 1'b0;

      if (clr_flag)
        flag <= 1'b0;
      else if (overflow)
        flag <= 1'b1;
    end
  end

endmodule

// File: rtl/jt51_timer_bank.sv
// rtl/jt51_timer_bank.sv - bank of CH timer channels with shared active-low irq (chain port with JT51_TIMER_BANK_CHAIN_EN)
module jt51_timer_bank
  import jt51_timer_pkg::*;
#(
  parameter int CH     = 2,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int MULT_W = DEF_MULT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic [CH*CNT_W-1:0] start_value,
  input  logic [CH-1:0]       load,
  input  logic [CH-1:0]       set_run,
  input  logic [CH-1:0]       clr_run,
  input  logic [CH-1:0]       clr_flag,
  input  logic [CH-1:0]       oneshot,
  input  logic [CH-1:0]       irq_en,
`ifdef JT51_TIMER_BANK_CHAIN_EN
  input  logic [CH-1:0]       chain,
`endif
  output logic [CH-1:0]       flag,
  output logic [CH-1:0]       overflow,
  output logic [CH-1:0]       running,
  output logic                irq_n
);

`ifdef JT51_TIMER_BANK_CHAIN_EN
  // Slot 0 is a constant zero so channel 0 never sees a predecessor.
  logic [CH:0] prev_ovf;
  assign prev_ovf = {overflow, 1'b0};
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jt51_timer_ch #(
      .CNT_W  (CNT_W),
      .MULT_W (MULT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .cen         (cen),
      .start_value (start_value[i*CNT_W +: CNT_W]),
      .load        (load[i]),
      .set_run     (set_run[i]),
      .clr_run     (clr_run[i]),
      .clr_flag    (clr_flag[i]),
      .oneshot     (oneshot[i]),
`ifdef JT51_TIMER_BANK_CHAIN_EN
      .chain_en    (chain[i] & (i != 0)),
      .chain_tick  (prev_ovf[i]),
`endif
      .flag        (flag[i]),
      .overflow    (overflow[i]),
      .running     (running[i])
    );
  end

  assign irq_n = ~|(flag & irq_en);

endmodule

// File: tb/tb_jt51_timer_bank.sv
// tb/tb_jt51_timer_bank.sv - directed self-checking bench for jt51_timer_bank
module tb_jt51_timer_bank;

  localparam int CH = 2, CNT_W = 10, MULT_W = 6;

  logic clk = 1'b0, rst = 1'b1, cen = 1'b0;
  logic [CH*CNT_W-1:0] start_value = '0;
  logic [CH-1:0] load = '0, set_run = '0, clr_run = '0, clr_flag = '0, oneshot = '0, irq_en = '0;
  logic [CH-1:0] flag, overflow, running;
  logic irq_n;
`ifdef JT51_TIMER_BANK_CHAIN_EN
  logic [CH-1:0] chain = '0;
`endif

  int errors = 0;
  int checks = 0;

  jt51_timer_bank #(.CH(CH), .CNT_W(CNT_W), .MULT_W(MULT_W)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start_value(start_value),
    .load(load), .set_run(set_run), .clr_run(clr_run), .clr_flag(clr_flag),
    .oneshot(oneshot), .irq_en(irq_en),
`ifdef JT51_TIMER_BANK_CHAIN_EN
    .chain(chain),
`endif
    .flag(flag), .overflow(overflow), .running(running), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_ch0();
    clr_run[0] = 1'b1; clr_flag[0] = 1'b1;
    tick();
    clr_run[0] = 1'b0; clr_flag[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cen = i[0];
      tick();
    end
    chk("reset_flag", 32'(flag), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    chk("reset_irq_n", 32'(irq_n), 32'h1);
    rst = 1'b0;
    cen = 1'b1;
  endtask

  task automatic test_single_period();
    int first = 0, second = 0, pulses = 0;
    start_value[0 +: CNT_W] = 10'h3FE;
    oneshot[0] = 1'b0;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      if (overflow[0]) begin
        pulses++;
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      if (k == 127) chk("period_flag_before", 32'(flag[0]), 32'h0);
      tick();
      if (k == 128) chk("period_flag_after", 32'(flag[0]), 32'h1);
    end
    chk("period_first_tick", 32'(first), 32'd128);
    chk("period_second_tick", 32'(second), 32'd256);
    chk("period_pulses", 32'(pulses), 32'd2);
    chk("period_running", 32'(running[0]), 32'h1);
    chk("period_ch1_idle", 32'({flag[1], overflow[1], running[1]}), 32'h0);
    clear_ch0();
  endtask

  task automatic test_oneshot();
    int first = 0, pulses = 0;
    start_value[0 +: CNT_W] = 10'h3FF;
    oneshot[0] = 1'b1;
    irq_en[0] = 1'b1;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int k = 1; k <= 264; k++) begin
      if (overflow[0]) begin
        pulses++;
        if (first == 0) first = k;
      end
      tick();
    end
    chk("oneshot_first_tick", 32'(first), 32'd64);
    chk("oneshot_pulses", 32'(pulses), 32'd1);
    chk("oneshot_running", 32'(running[0]), 32'h0);
    chk("oneshot_flag", 32'(flag[0]), 32'h1);
    chk("oneshot_irq_n", 32'(irq_n), 32'h0);
    // Reset mid-activity must also clear a set flag.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rereset_flag", 32'(flag), 32'h0);
    chk("rereset_irq_n", 32'(irq_n), 32'h1);
    oneshot[0] = 1'b0;
  endtask

  task automatic test_clr_flag_collision();
    int pulses = 0, first = 0;
    start_value[0 +: CNT_W] = 10'h3FF;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int k = 1; k < 64; k++) tick();
    chk("collide_overflow", 32'(overflow[0]), 32'h1);
    clr_flag[0] = 1'b1;
    tick();
    clr_flag[0] = 1'b0;
    chk("collide_flag", 32'(flag[0]), 32'h0);
    chk("collide_running", 32'(running[0]), 32'h1);
    // load with clr_run: reloads but leaves the channel stopped.
    for (int k = 0; k < 10; k++) tick();
    load[0] = 1'b1; clr_run[0] = 1'b1;
    tick();
    load[0] = 1'b0; clr_run[0] = 1'b0;
    chk("loadclr_running", 32'(running[0]), 32'h0);
    for (int k = 0; k < 200; k++) begin
      if (overflow[0]) pulses++;
      tick();
    end
    chk("loadclr_no_ovf", 32'(pulses), 32'h0);
    chk("loadclr_flag", 32'(flag[0]), 32'h0);
    set_run[0] = 1'b1;
    tick();
    set_run[0] = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (overflow[0] && first == 0) first = k;
      tick();
    end
    chk("loadclr_reload_tick", 32'(first), 32'd64);
    clear_ch0();
  endtask

  task automatic test_stopped_all_ones();
    int pulses = 0;
    start_value[0 +: CNT_W] = 10'h3FF;
    load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    for (int k = 1; k <= 62; k++) tick();
    clr_run[0] = 1'b1;
    tick();
    clr_run[0] = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (overflow[0]) pulses++;
      tick();
    end
    chk("stopped_no_ovf", 32'(pulses), 32'h0);
    chk("stopped_flag", 32'(flag[0]), 32'h0);
    chk("stopped_running", 32'(running[0]), 32'h0);
    // The accumulator was left at all-ones, so restarting wraps immediately.
    set_run[0] = 1'b1;
    tick();
    set_run[0] = 1'b0;
    chk("restart_overflow", 32'(overflow[0]), 32'h1);
    tick();
    chk("restart_flag", 32'(flag[0]), 32'h1);
    irq_en = 2'b00;
    #1;
    chk("mask_irq_n_off", 32'(irq_n), 32'h1);
    irq_en = 2'b10;
    #1;
    chk("mask_irq_n_other", 32'(irq_n), 32'h1);
    irq_en = 2'b01;
    #1;
    chk("mask_irq_n_on", 32'(irq_n), 32'h0);
    irq_en = 2'b00;
    clear_ch0();
  endtask

  task automatic test_cen_gating();
    int ticks = 0, first = 0;
    start_value[CNT_W +: CNT_W] = 10'h3FF;
    oneshot[1] = 1'b1;
    load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      cen = c[0];
      if (cen) begin
        ticks++;
        if (overflow[1] && first == 0) first = ticks;
      end
      tick();
    end
    cen = 1'b1;
    chk("cen_first_tick", 32'(first), 32'd64);
    chk("cen_ch1_stopped", 32'(running[1]), 32'h0);
    chk("cen_ch1_flag", 32'(flag[1]), 32'h1);
    chk("cen_ch0_untouched", 32'(flag[0]), 32'h0);
    clr_flag[1] = 1'b1;
    tick();
    clr_flag[1] = 1'b0;
    oneshot[1] = 1'b0;
  endtask

`ifdef JT51_TIMER_BANK_CHAIN_EN
  task automatic test_chain();
    int first = 0;
    start_value[0 +: CNT_W] = 10'h3FF;
    start_value[CNT_W +: CNT_W] = 10'h3FE;
    chain = 2'b11;
    load = 2'b11;
    tick();
    load = 2'b00;
    for (int k = 1; k <= 8300; k++) begin
      if (overflow[1] && first == 0) first = k;
      tick();
    end
    chk("chain_first_tick", 32'(first), 32'd8192);
    clr_run = 2'b11; clr_flag = 2'b11;
    tick();
    clr_run = 2'b00; clr_flag = 2'b00;
    chain = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_single_period();
    test_oneshot();
    test_clr_flag_collision();
    test_stopped_all_ones();
    test_cen_gating();
`ifdef JT51_TIMER_BANK_CHAIN_EN
    test_chain();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt51_timer_bank.md
Name: jt51_timer_bank

Overview:
- Parametrised bank of CH independent up-counting timers with prescalers, for the OPM/OPN-style register front-ends in the JT51 core.
- Adds the following per channel:
  - one-shot or auto-reload mode;
  - run-qualified overflow;
  - irq enable mask;
  - fully reset counters.
- Aggregates channel flags into one active-low irq_n.
- Sits beside the register decoder and is clocked by the core's cen tick.

Parameters:
- CH, 2, number of timer channels (1..8).
- CNT_W, 10, counter width in bits.
- MULT_W, 6, prescaler width in bits; one counter step every 2^MULT_W cen ticks.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- cen  in  1  clock enable; all state changes happen only on clk edges with cen=1.
- start_value  in  CH*CNT_W  per-channel reload value; channel i uses slice [i*CNT_W +: CNT_W].
- load  in  CH  per-channel immediate reload, which also starts the channel.
- set_run  in  CH  per-channel start without reload.
- clr_run  in  CH  per-channel stop.
- clr_flag  in  CH  per-channel flag clear.
- oneshot  in  CH  per-channel mode: 1 = stop after overflow, 0 = auto-reload.
- irq_en  in  CH  per-channel irq enable mask.
- flag  out  CH  per-channel sticky overflow flag.
- overflow  out  CH  per-channel combinational overflow strobe.
- running  out  CH  per-channel run state.
- irq_n  out  1  active-low interrupt: ~|(flag & irq_en).

Behaviour:
- State per channel: run, cnt[CNT_W], mult[MULT_W]. The concatenation {cnt,mult} forms an accumulator of CNT_W+MULT_W bits.
- Reset (rst=1 at a clk edge, cen is ignored):
  - run=0, cnt=0, mult=0, flag=0;
  - therefore overflow=0, running=0, irq_n=1.
- overflow[i] = run[i] & (&{cnt,mult}).
  - Combinational.
  - Asserted during the cen tick on which the accumulator wraps.
- Counter update on each cen tick, in priority order:
  1. load[i]: cnt<=start_value, mult<=0.
  2. Else if run[i] and overflow[i]: cnt<=start_value, mult<=0. The value sampled is start_value on that tick.
  3. Else if run[i]: {cnt,mult}<={cnt,mult}+1. Arithmetic is modulo 2^(CNT_W+MULT_W).
  4. Else: hold.
- Run update on each cen tick, in priority order:
  1. clr_run: run<=0.
  2. Else if set_run or load: run<=1.
  3. Else if overflow and oneshot: run<=0.
  4. Else: hold.
- Flag update on each cen tick:
  - clr_flag: flag<=0. This wins over a simultaneous overflow.
  - Else if overflow: flag<=1.
- Overflow period: (2^CNT_W - start_value) * 2^MULT_W cen ticks, counted from the tick after load.
  - start_value = all-ones gives 2^MULT_W ticks.
- Boundary cases:
  - load together with clr_run: the counter reloads and run=0.
  - load while running: the count restarts with no overflow strobe.
  - A stopped channel never asserts overflow, even with the accumulator at all-ones.
  - Changing start_value mid-count only affects the next reload.
  - oneshot changes take effect at the next overflow.
- running = run. flag and running are registered; irq_n is combinational from registers and the irq_en input.

Optional Feature:
- Macro: JT51_TIMER_BANK_CHAIN_EN.
- When defined:
  - Adds input chain[CH].
  - For i>0 with chain[i]=1, channel i advances its accumulator only on ticks where overflow[i-1]=1, instead of every cen tick. This gives a cascaded CNT_W*2-class period.
  - chain[0] is ignored.
- When undefined:
  - The port is absent.
  - All channels advance every cen tick as described above.

Decomposition:
- Package jt51_timer_pkg holds:
  - localparams for default CNT_W/MULT_W;
  - mode encodings MODE_RELOAD=0 and MODE_ONESHOT=1;
  - a function computing the period in cen ticks, for benches.
- Sub-module jt51_timer_ch implements one channel (run, accumulator, flag, overflow; chain-enable input when the macro is defined). The top level generates CH instances and reduces irq_n.

Test Plan:
- Reset check: CH=2, CNT_W=10, MULT_W=6; assert rst for 3 cycles while cen toggles -> flag=0, running=0, overflow=0, irq_n=1.
- Single period: load[0] with start 0x3FE, cen every cycle, auto-reload -> overflow[0] pulses on the 128th tick after load, flag[0]=1 on the next edge, next pulse 128 ticks later.
- One-shot: start 0x3FF, oneshot[0]=1, irq_en[0]=1 -> one overflow after 64 ticks, then running[0]=0, irq_n=0; no further pulses over 200 ticks.
- Simultaneous clr_flag and overflow on the wrap tick -> flag stays 0. clr_run with load -> counter reloaded, running=0, no overflow afterwards.
- Stopped at all-ones: load 0x3FF, run 63 ticks, clr_run -> overflow stays 0 and flag stays 0 indefinitely; irq mask check with irq_en=0 plus flag=1 -> irq_n=1.
- Chain (macro defined): ch0 start 0x3FF with MULT_W=6, ch1 chained with start 0x3FE -> ch1 overflows after 2*2^6=128 ch0 overflows = 8192 ticks.
